// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor
//   Post-processing stage for a 2-bit magnitude comparator. Samples the
//   one-hot gt/eq/lt flags, qualifies them over STABLE_CYC consecutive
//   identical valid samples, emits a change-only result code over a
//   valid/ready handshake and keeps saturating per-outcome counters.
//
//   Build option: define CMP_MON_ERRCHK_EN to decode non-one-hot flag sets
//   as code 11 and raise the sticky err_flag when such a code is accepted.
//   Without it, flags are priority-decoded (gt, then eq, then lt) and
//   err_flag is tied low.
module cmp_result_monitor #(
    parameter int CNT_W      = 8,
    parameter int STABLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             err_flag
);

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // Result codes
    localparam logic [1:0] CODE_EQ = 2'b00;
    localparam logic [1:0] CODE_GT = 2'b01;
    localparam logic [1:0] CODE_LT = 2'b10;
`ifdef CMP_MON_ERRCHK_EN
    localparam logic [1:0] CODE_ERR = 2'b11;
`endif

    localparam logic [3:0]       STAB_TGT = 4'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [3:0]       stab_q, stab_d;
    logic [1:0]       last_q, last_d;
    logic             last_vld_q, last_vld_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;

    logic [1:0] code;
    logic [3:0] stab_inc;
    logic       accept;

    // Decode the sampled flag set into a result code
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        code = CODE_LT;
`ifdef CMP_MON_ERRCHK_EN
        unique case ({a_gt_b, a_eq_b, a_lt_b})
            3'b100:  code = CODE_GT;
            3'b010:  code = CODE_EQ;
            3'b001:  code = CODE_LT;
            default: code = CODE_ERR;
        endcase
`else
        if (a_gt_b) begin
            code = CODE_GT;
        end else if (a_eq_b) begin
            code = CODE_EQ;
        end else begin
            code = CODE_LT;
        end
`endif
    end

    assign accept   = (state_q == ST_EMIT) && out_ready;
    assign stab_inc = stab_q + 4'd1;

    // Qualification / emission FSM and change-history tracking
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stab_d     = stab_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cand_d = code;
                    stab_d = 4'd1;
                    if (STAB_TGT == 4'd1) begin
                        // Single-sample qualification: only a change is emitted
                        if (!last_vld_q || (code != last_q)) begin
                            state_d = ST_EMIT;
                        end
                    end else begin
                        state_d = ST_QUAL;
                    end
                end
            end
            ST_QUAL: begin
                if (in_valid) begin
                    if (code == cand_q) begin
                        stab_d = stab_inc;
                        if (stab_inc == STAB_TGT) begin
                            // Stable result: drop it if it repeats the last one
                            if (last_vld_q && (cand_q == last_q)) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_EMIT;
                            end
                        end
                    end else begin
                        cand_d = code;
                        stab_d = 4'd1;
                    end
                end
            end
            ST_EMIT: begin
                // Inputs are ignored while a result waits for the consumer
                if (out_ready) begin
                    last_d     = cand_q;
                    last_vld_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear forgets the change history but leaves the FSM untouched
        if (clr) begin
            last_vld_d = 1'b0;
        end
    end

    // Saturating per-outcome counters, updated on an accepted result
    always_comb begin
        gt_cnt_d = gt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        lt_cnt_d = lt_cnt_q;

        if (accept) begin
            unique case (cand_q)
                CODE_GT: if (gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + CNT_W'(1);
                CODE_EQ: if (eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + CNT_W'(1);
                CODE_LT: if (lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + CNT_W'(1);
                default: ;
            endcase
        end

        // Clear takes priority over a coincident acceptance
        if (clr) begin
            gt_cnt_d = '0;
            eq_cnt_d = '0;
            lt_cnt_d = '0;
        end
    end

    // State, history and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cand_q     <= CODE_EQ;
            stab_q     <= 4'd0;
            last_q     <= CODE_EQ;
            last_vld_q <= 1'b0;
            gt_cnt_q   <= '0;
            eq_cnt_q   <= '0;
            lt_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            gt_cnt_q   <= gt_cnt_d;
            eq_cnt_q   <= eq_cnt_d;
            lt_cnt_q   <= lt_cnt_d;
        end
    end

`ifdef CMP_MON_ERRCHK_EN
    logic err_q, err_d;

    // Sticky error: set when an illegal code is accepted, cleared by clr
    always_comb begin
        err_d = err_q;
        if (accept && (cand_q == CODE_ERR)) begin
            err_d = 1'b1;
        end
        if (clr) begin
            err_d = 1'b0;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

    assign out_valid = (state_q == ST_EMIT);
    assign out_code  = cand_q;
    assign gt_cnt    = gt_cnt_q;
    assign eq_cnt    = eq_cnt_q;
    assign lt_cnt    = lt_cnt_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor
//   Directed bench for cmp_result_monitor with a narrow counter (CNT_W=2) so
//   saturation is reachable. A run-length model of the qualification rules is
//   compared with the DUT on every falling edge; directed steps also pin
//   hand-computed values. Honours CMP_MON_ERRCHK_EN the same way the DUT does.
module tb_cmp_result_monitor;

    localparam int CNT_W      = 2;
    localparam int STABLE_CYC = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_code;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic             err_flag;

    int n_checks = 0;
    int n_errors = 0;

    cmp_result_monitor #(
        .CNT_W      (CNT_W),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .gt_cnt    (gt_cnt),
        .eq_cnt    (eq_cnt),
        .lt_cnt    (lt_cnt),
        .err_flag  (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] decode(input logic g, input logic e, input logic l);
`ifdef CMP_MON_ERRCHK_EN
        if ((32'(g) + 32'(e) + 32'(l)) != 1) return 2'b11;
        return g ? 2'b01 : (e ? 2'b00 : 2'b10);
`else
        return g ? 2'b01 : (e ? 2'b00 : 2'b10);
`endif
    endfunction

    int         m_gt, m_eq, m_lt;
    bit         m_err;
    bit         m_pend;
    logic [1:0] m_pend_code;
    logic [1:0] m_run_code;
    int         m_run_len;
    logic [1:0] m_last;
    bit         m_last_vld;

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] c;
        if (!rst_n) begin
            m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
            m_pend = 0; m_pend_code = 2'b00;
            m_run_code = 2'b00; m_run_len = 0;
            m_last = 2'b00; m_last_vld = 0;
        end else begin
            if (m_pend) begin
                if (out_ready) begin
                    case (m_pend_code)
                        2'b01:   m_gt = (m_gt < CNT_MAX) ? m_gt + 1 : CNT_MAX;
                        2'b00:   m_eq = (m_eq < CNT_MAX) ? m_eq + 1 : CNT_MAX;
                        2'b10:   m_lt = (m_lt < CNT_MAX) ? m_lt + 1 : CNT_MAX;
                        default: m_err = 1;
                    endcase
                    m_last     = m_pend_code;
                    m_last_vld = 1;
                    m_pend     = 0;
                    m_run_len  = 0;
                end
            end else if (in_valid) begin
                c = decode(a_gt_b, a_eq_b, a_lt_b);
                if (m_run_len > 0 && c == m_run_code) begin
                    m_run_len++;
                end else begin
                    m_run_code = c;
                    m_run_len  = 1;
                end
                if (m_run_len >= STABLE_CYC) begin
                    if (m_last_vld && m_run_code == m_last) begin
                        m_run_len = 0;
                    end else begin
                        m_pend      = 1;
                        m_pend_code = m_run_code;
                    end
                end
            end
            if (clr) begin
                m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
                m_last_vld = 0;
            end
        end
    end

    // Compare DUT against the model once per cycle, away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_pend));
            if (m_pend) check("out_code", 32'(out_code), 32'(m_pend_code));
            check("gt_cnt", 32'(gt_cnt), 32'(m_gt));
            check("eq_cnt", 32'(eq_cnt), 32'(m_eq));
            check("lt_cnt", 32'(lt_cnt), 32'(m_lt));
            check("err_flag", 32'(err_flag), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic g, input logic e, input logic l,
                         input logic r, input logic c);
        in_valid  = v;
        a_gt_b    = g;
        a_eq_b    = e;
        a_lt_b    = l;
        out_ready = r;
        clr       = c;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_illegal;
        int         exp_gt_after_illegal;
`ifdef CMP_MON_ERRCHK_EN
        exp_illegal          = 2'b11;
        exp_gt_after_illegal = 1;
`else
        exp_illegal          = 2'b01;
        exp_gt_after_illegal = 2;
`endif

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Reset values
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_code", 32'(out_code), 32'd0);
        check("rst gt_cnt", 32'(gt_cnt), 32'd0);
        check("rst eq_cnt", 32'(eq_cnt), 32'd0);
        check("rst lt_cnt", 32'(lt_cnt), 32'd0);
        check("rst err_flag", 32'(err_flag), 32'd0);

        // gt stable for two samples: one pulse with code 01
        drive(1, 1, 0, 0, 1, 0);
        tick(2);
        check("gt emit valid", 32'(out_valid), 32'd1);
        check("gt emit code", 32'(out_code), 32'd1);
        drive(0, 0, 0, 0, 1, 0);
        tick(1);
        check("gt pulse ends", 32'(out_valid), 32'd0);
        check("gt_cnt after gt", 32'(gt_cnt), 32'd1);
        tick(2);

        // eq held six cycles: one emission, repeats suppressed
        drive(1, 0, 1, 0, 1, 0);
        tick(6);
        drive(0, 0, 0, 0, 1, 0);
        tick(3);
        check("eq_cnt single", 32'(eq_cnt), 32'd1);

        // alternating lt/gt never qualifies
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(1, 0, 0, 1, 1, 0);
            else            drive(1, 1, 0, 0, 1, 0);
            tick(1);
        end
        check("alt no gt", 32'(gt_cnt), 32'd1);
        check("alt no lt", 32'(lt_cnt), 32'd0);

        // lt with back-pressure: held, then accepted
        drive(1, 0, 0, 1, 0, 0);
        tick(2);
        tick(5);
        check("lt held valid", 32'(out_valid), 32'd1);
        check("lt held code", 32'(out_code), 32'd2);
        check("lt held cnt", 32'(lt_cnt), 32'd0);
        drive(0, 0, 0, 0, 1, 0);
        tick(1);
        check("lt accepted cnt", 32'(lt_cnt), 32'd1);
        check("lt accepted valid", 32'(out_valid), 32'd0);

        // non-one-hot gt+eq
        drive(1, 1, 1, 0, 0, 0);
        tick(2);
        check("illegal code", 32'(out_code), 32'(exp_illegal));
        drive(0, 0, 0, 0, 1, 0);
        tick(1);
        check("illegal gt_cnt", 32'(gt_cnt), 32'(exp_gt_after_illegal));
`ifdef CMP_MON_ERRCHK_EN
        check("illegal err_flag", 32'(err_flag), 32'd1);
`endif
        drive(0, 0, 0, 0, 0, 1);
        tick(1);
        check("clr err_flag", 32'(err_flag), 32'd0);
        check("clr gt_cnt", 32'(gt_cnt), 32'd0);
        check("clr lt_cnt", 32'(lt_cnt), 32'd0);

        // six gt results separated by eq: saturation at 3
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 1, 0);
            tick(3);
            drive(1, 0, 1, 0, 1, 0);
            tick(3);
        end
        check("sat gt_cnt", 32'(gt_cnt), 32'd3);
        check("sat eq_cnt", 32'(eq_cnt), 32'd3);

        // clr coincident with acceptance wins, and forgets history
        drive(1, 1, 0, 0, 0, 0);
        tick(2);
        check("pend gt valid", 32'(out_valid), 32'd1);
        drive(0, 0, 0, 0, 1, 1);
        tick(1);
        check("clr+acc gt_cnt", 32'(gt_cnt), 32'd0);
        check("clr+acc valid", 32'(out_valid), 32'd0);
        drive(1, 1, 0, 0, 1, 0);
        tick(3);
        check("gt after clr history", 32'(gt_cnt), 32'd1);

        // clr while a result is pending keeps it pending
        drive(1, 0, 1, 0, 0, 0);
        tick(2);
        drive(0, 0, 0, 0, 0, 1);
        tick(1);
        check("clr keeps pending", 32'(out_valid), 32'd1);
        drive(0, 0, 0, 0, 1, 0);
        tick(1);
        check("eq after pending clr", 32'(eq_cnt), 32'd1);

        // asynchronous reset mid-EMIT drops the result immediately
        drive(1, 0, 0, 1, 0, 0);
        tick(2);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async reset valid", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0, 1, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("post-reset gt_cnt", 32'(gt_cnt), 32'd0);
        check("post-reset eq_cnt", 32'(eq_cnt), 32'd0);
        check("post-reset lt_cnt", 32'(lt_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
